// File: rtl/flag_register_stack.sv
// flag_register_stack: ALU condition-flag register with a small save/restore
// stack. All state updates happen on the falling edge of clock.
// Optional feature: define FLAG_STACK_ERR_EN to enable the sticky stack_err
// indicator for illegal push/pop (push while full, pop while empty). When the
// macro is undefined, stack_err is tied to 0 and err_clr is ignored.
module flag_register_stack #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NFLAGS-1:0] flags_in,
    input  logic [NFLAGS-1:0] flag_we,
    input  logic              update,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic [NFLAGS-1:0] flags_out,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              stack_err
);

    // Index width for the stack array; kept at least 1 bit for DEPTH=1.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] stack [DEPTH];
    logic [NFLAGS-1:0] flags_q;
    logic [NFLAGS-1:0] flags_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              push_ok;
    logic              pop_ok;
    logic              bad_op;

    // Occupancy decodes are purely combinational; count never wraps.
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));

    // Simultaneous push+pop cancels out; illegal operations are dropped.
    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign bad_op  = (push & ~pop & full) | (pop & ~push & empty);

    assign wr_idx = AW'(count_q);
    assign rd_idx = AW'(count_q - CW'(1));

    // Next flags and occupancy: a legal pop restores and discards any update.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        flags_d = flags_q;
        count_d = count_q;
        if (pop_ok) begin
            flags_d = stack[rd_idx];
            count_d = count_q - CW'(1);
        end else begin
            if (update) begin
                flags_d = (flags_q & ~flag_we) | (flags_in & flag_we);
            end
            if (push_ok) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Flag register and occupancy counter, cleared asynchronously.
    always_ff @(negedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            flags_q <= '0;
            count_q <= '0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
        end
    end

    // Stack storage captures the pre-edge flags on a legal push.
    always_ff @(negedge clock) begin
        // NOTE: the stack array has no reset; entries above count are never
        // read, so clearing them would only cost reset fan-out.
        if (push_ok) begin
            stack[wr_idx] <= flags_q;
        end
    end

`ifdef FLAG_STACK_ERR_EN
    logic err_q;

    // Sticky error: a new illegal operation wins over a same-edge clear.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (bad_op) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign stack_err = err_q;
`else
    // Feature disabled: illegal operations are still dropped, never flagged.
    logic unused_err_inputs;
    assign unused_err_inputs = err_clr | bad_op;
    assign stack_err         = 1'b0;
`endif

    assign flags_out = flags_q;
    assign count     = count_q;

endmodule

// File: doc/flag_register_stack.md
FLAG_REGISTER_STACK -- requirements
Module: flag_register_stack

Interface
REQ-001 SHALL provide parameter NFLAGS, default 4, number of flag bits (bit0 Z, bit1 C, bit2 S, bit3 O; extra bits user-defined).
REQ-002 SHALL provide parameter DEPTH, default 4, number of save-stack entries (legal range 1..16).
REQ-003 SHALL provide parameter CW, default $clog2(DEPTH+1), width of the occupancy counter.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; port list starts with clock and reset.
REQ-005 clock  input  1  system clock; all state updates on its falling edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 flags_in  input  NFLAGS  new flag values from the ALU.
REQ-008 flag_we  input  NFLAGS  per-flag write mask, decoded from the operation.
REQ-009 update  input  1  strobe; apply flags_in under flag_we this edge.
REQ-010 push  input  1  save current flags onto the stack.
REQ-011 pop  input  1  restore flags from the top of the stack.
REQ-012 err_clr  input  1  clear the sticky error.
REQ-013 flags_out  output  NFLAGS  registered current flags.
REQ-014 count  output  CW  number of occupied stack entries.
REQ-015 empty  output  1  count==0.
REQ-016 full  output  1  count==DEPTH.
REQ-017 stack_err  output  1  sticky illegal push/pop indicator.

Function
REQ-018 On each falling clock edge with update=1, flags_out[i] SHALL take flags_in[i] for every i with flag_we[i]=1; other bits hold.
REQ-019 update=1 with flag_we=0 SHALL leave flags_out unchanged.
REQ-020 push=1, pop=0, not full: stack[count] SHALL take the pre-edge flags_out; count SHALL increment by 1 on that edge.
REQ-021 push with a same-edge update: the stack SHALL store the pre-update value; flags_out SHALL take the update.
REQ-022 pop=1, push=0, not empty: flags_out SHALL take stack[count-1]; count SHALL decrement by 1 on that edge.
REQ-023 pop SHALL take priority over update on the same edge; the update is discarded entirely.
REQ-024 push and pop on the same edge SHALL be a no-op for stack and count; update then applies normally.
REQ-025 push while full, or pop while empty, SHALL be ignored (stack, count and flags_out unaffected except by update) and SHALL set stack_err.
REQ-026 stack_err SHALL stay at 1 until err_clr=1 on a falling edge; if a new error and err_clr occur on the same edge, the error wins.
REQ-027 Outputs empty and full SHALL be combinational decodes of count; there is no wrap-around of count.
REQ-028 Latency: flags_out and count reflect an operation immediately after the falling edge that samples it; no pipelining.

Reset
REQ-029 reset=1 SHALL immediately force flags_out=0, count=0, stack_err=0, empty=1 and full=0, independent of clock.
REQ-030 Stack entry contents SHALL be don't-care after reset; they are unreadable because count=0.
REQ-031 reset asserted mid-operation SHALL override any push/pop/update sampled on the same edge.

Configuration
REQ-032 Macro FLAG_STACK_ERR_EN: when defined, stack_err and err_clr behave per REQ-025/026.
REQ-033 Without FLAG_STACK_ERR_EN, stack_err SHALL be constant 0, err_clr SHALL be ignored, and illegal push/pop SHALL still be silently ignored.

Verification
REQ-034 After reset, update=1, flag_we=4'b1111, flags_in=4'b1010 -> flags_out=4'b1010, count=0, empty=1.
REQ-035 flags_out=4'b1010; update, flag_we=4'b0101, flags_in=4'b0101 -> flags_out=4'b1111.
REQ-036 flags_out=4'b0011; push with update flags_in=4'b1100, we=4'b1111 -> flags_out=4'b1100, count=1; then pop -> flags_out=4'b0011, count=0.
REQ-037 DEPTH=4: five pushes -> count=4, full=1, stack_err=1 after the fifth; err_clr -> stack_err=0, count still 4.
REQ-038 Empty stack: pop with update flags_in=4'b1111, we=4'b1111 -> pop ignored, stack_err=1, flags_out=4'b1111; with FLAG_STACK_ERR_EN undefined, stack_err=0.
REQ-039 count=2: reset pulse between clock edges -> flags_out=0, count=0, stack_err=0 immediately; simultaneous push+pop at count=1 -> count stays 1.
